uart_reg_file: RTL and testbench

UART_REG_FILE -- requirements
Module: uart_reg_file

---
 rtl/uart_reg_file_if.sv | 16 +
 rtl/uart_reg_file.sv | 166 ++++++++++++++++
 tb/tb_uart_reg_file.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_file_if.sv
// uart_reg_file_if: register-access bus between an APB slave front end and the UART register file.
//   master drives waddr/wdata/wr_en and raddr/rd_en; slave returns rdata, wack/rack and waddrerr/raddrerr.
interface uart_reg_file_if;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [11:0] raddr;
    logic        rd_en;
    logic [31:0] rdata;
    logic        wack;
    logic        rack;
    logic        waddrerr;
    logic        raddrerr;
    modport master (output waddr, wdata, wr_en, raddr, rd_en, input rdata, wack, rack, waddrerr, raddrerr);
    modport slave  (input waddr, wdata, wr_en, raddr, rd_en, output rdata, wack, rack, waddrerr, raddrerr);
endinterface

// File: rtl/uart_reg_file.sv
// uart_reg_file: UART control/status registers with 8-deep TX and RX byte FIFOs.
//   pclk/prst_n      clock, asynchronous active-low reset
//   bus              edge-triggered register reads/writes with one-cycle acks and address errors
//   tx_data/tx_valid/tx_ready   TX FIFO head towards the transmitter
//   rx_data/rx_valid            byte pushes from the receiver
//   baud_div/tx_en/rx_en        configuration towards the UART core
module uart_reg_file #(
    parameter logic [15:0] BAUD_RST = 16'd27
) (
    input  logic              pclk,
    input  logic              prst_n,
    uart_reg_file_if.slave    bus,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [15:0]       baud_div,
    output logic              tx_en,
    output logic              rx_en
);
    localparam logic [11:0] A_TX   = 12'h000;
    localparam logic [11:0] A_RX   = 12'h004;
    localparam logic [11:0] A_CTRL = 12'h008;
    localparam logic [11:0] A_BAUD = 12'h00C;
    localparam logic [11:0] A_STAT = 12'h010;

    logic        r_wr_d, r_rd_d;
    logic        r_wack, r_rack, r_werr, r_rerr;
    logic [31:0] r_rdata;
    logic        r_tx_en, r_rx_en, r_tx_ovf, r_rx_ovr;
    logic [15:0] r_baud;
    logic [7:0]  r_tx_mem [8];
    logic [7:0]  r_rx_mem [8];
    logic [2:0]  r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [3:0]  r_tx_cnt, r_rx_cnt;

    logic        w_wacc, w_racc, w_wmap, w_rmap;
    logic        w_wr_ctrl, w_wr_baud, w_wr_stat, w_tx_clr, w_rx_clr;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_push_req, w_tx_push, w_tx_pop;
    logic        w_rx_push_req, w_rx_push, w_rx_pop;
    logic [31:0] w_status, w_rval;
    logic        w_unused;

    // Only a 0->1 transition of the request level starts an access.
    assign w_wacc = bus.wr_en & ~r_wr_d;
    assign w_racc = bus.rd_en & ~r_rd_d;
    assign w_wmap = bus.waddr inside {A_TX, A_CTRL, A_BAUD, A_STAT};
    assign w_rmap = bus.raddr inside {A_RX, A_CTRL, A_BAUD, A_STAT};
    assign w_wr_ctrl = w_wacc & (bus.waddr == A_CTRL);
    assign w_wr_baud = w_wacc & (bus.waddr == A_BAUD);
    assign w_wr_stat = w_wacc & (bus.waddr == A_STAT);
    assign w_tx_clr  = w_wr_ctrl & bus.wdata[2];
    assign w_rx_clr  = w_wr_ctrl & bus.wdata[3];

    assign w_tx_full  = r_tx_cnt == 4'd8;
    assign w_tx_empty = r_tx_cnt == 4'd0;
    assign w_rx_full  = r_rx_cnt == 4'd8;
    assign w_rx_empty = r_rx_cnt == 4'd0;

    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    assign w_tx_pop      = tx_valid & tx_ready;
    assign w_tx_push_req = w_wacc & (bus.waddr == A_TX);
    assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
    assign w_rx_pop      = w_racc & (bus.raddr == A_RX) & ~w_rx_empty;
    assign w_rx_push_req = rx_valid & r_rx_en;
    assign w_rx_push     = w_rx_push_req & (~w_rx_full | w_rx_pop);

    assign w_status = {18'b0, r_tx_ovf, r_rx_ovr, r_rx_cnt, r_tx_cnt, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
    assign w_rval = (bus.raddr == A_RX)   ? (w_rx_empty ? 32'b0 : {24'b0, r_rx_mem[r_rx_rp]}) :
                    (bus.raddr == A_CTRL) ? {30'b0, r_rx_en, r_tx_en} :
                    (bus.raddr == A_BAUD) ? {16'b0, r_baud} :
                    (bus.raddr == A_STAT) ? w_status : 32'b0;
    assign w_unused = &{1'b0, bus.wdata[31:16]};

    assign bus.wack     = r_wack;
    assign bus.rack     = r_rack;
    assign bus.waddrerr = r_werr;
    assign bus.raddrerr = r_rerr;
    assign bus.rdata    = r_rdata;
    assign tx_data      = r_tx_mem[r_tx_rp];
    assign tx_valid     = r_tx_en & ~w_tx_empty;
    assign baud_div     = r_baud;
    assign tx_en        = r_tx_en;
    assign rx_en        = r_rx_en;

    // Previous-level registers reset high so a level held through reset release is not an access.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_wr_d   <= 1'b1;
            r_rd_d   <= 1'b1;
            r_wack   <= 1'b0;
            r_rack   <= 1'b0;
            r_werr   <= 1'b0;
            r_rerr   <= 1'b0;
            r_rdata  <= 32'b0;
            r_tx_en  <= 1'b0;
            r_rx_en  <= 1'b0;
            r_baud   <= BAUD_RST;
            r_tx_ovf <= 1'b0;
            r_rx_ovr <= 1'b0;
        end else begin
            r_wr_d  <= bus.wr_en;
            r_rd_d  <= bus.rd_en;
            r_wack  <= w_wacc;
            r_rack  <= w_racc;
            r_werr  <= w_wacc & ~w_wmap;
            r_rerr  <= w_racc & ~w_rmap;
            r_rdata <= w_racc ? w_rval : 32'b0;
            if (w_wr_ctrl) begin
                r_tx_en <= bus.wdata[0];
                r_rx_en <= bus.wdata[1];
            end
            if (w_wr_baud)
                r_baud <= bus.wdata[15:0];
            // A new drop wins over a same-cycle write-one-to-clear.
            r_tx_ovf <= (w_tx_push_req & ~w_tx_push) | (r_tx_ovf & ~(w_wr_stat & bus.wdata[13]));
            r_rx_ovr <= (w_rx_push_req & ~w_rx_push) | (r_rx_ovr & ~(w_wr_stat & bus.wdata[12]));
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_tx_wp  <= 3'd0;
            r_tx_rp  <= 3'd0;
            r_tx_cnt <= 4'd0;
        end else if (w_tx_clr) begin
            r_tx_wp  <= 3'd0;
            r_tx_rp  <= 3'd0;
            r_tx_cnt <= 4'd0;
        end else begin
            if (w_tx_push)
                r_tx_wp <= r_tx_wp + 3'd1;
            if (w_tx_pop)
                r_tx_rp <= r_tx_rp + 3'd1;
            r_tx_cnt <= r_tx_cnt + {3'b0, w_tx_push} - {3'b0, w_tx_pop};
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_rx_wp  <= 3'd0;
            r_rx_rp  <= 3'd0;
            r_rx_cnt <= 4'd0;
        end else if (w_rx_clr) begin
            r_rx_wp  <= 3'd0;
            r_rx_rp  <= 3'd0;
            r_rx_cnt <= 4'd0;
        end else begin
            if (w_rx_push)
                r_rx_wp <= r_rx_wp + 3'd1;
            if (w_rx_pop)
                r_rx_rp <= r_rx_rp + 3'd1;
            r_rx_cnt <= r_rx_cnt + {3'b0, w_rx_push} - {3'b0, w_rx_pop};
        end
    end

    // Storage needs no reset: contents are only visible through valid counts.
    always_ff @(posedge pclk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp] <= bus.wdata[7:0];
        if (w_rx_push)
            r_rx_mem[r_rx_wp] <= rx_data;
    end
endmodule

// File: tb/tb_uart_reg_file.sv
// tb_uart_reg_file: randomized and directed checks of uart_reg_file against a queue-based register model.
module tb_uart_reg_file;
    logic        pclk = 1'b0;
    logic        prst_n = 1'b1;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid;
    logic [15:0] baud_div;
    logic        tx_en, rx_en;
    int          total = 0;
    int          bad = 0;

    uart_reg_file_if bus ();

    uart_reg_file #(.BAUD_RST(16'd27)) dut (
        .pclk(pclk), .prst_n(prst_n), .bus(bus.slave),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .baud_div(baud_div), .tx_en(tx_en), .rx_en(rx_en)
    );

    always #5 pclk = ~pclk;

    logic [7:0]  tx_q[$], rx_q[$];
    bit          m_txen, m_rxen, m_ovf, m_ovr, pw, pr;
    logic [15:0] m_baud;
    bit          e_wack, e_rack, e_werr, e_rerr;
    logic [31:0] e_rdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {18'b0, m_ovf, m_ovr, 4'(rx_q.size()), 4'(tx_q.size()),
                rx_q.size() == 0, rx_q.size() == 8, tx_q.size() == 0, tx_q.size() == 8};
    endfunction

    function automatic void m_reset();
        tx_q.delete();
        rx_q.delete();
        {m_txen, m_rxen, m_ovf, m_ovr} = 4'b0;
        m_baud = 16'd27;
        pw = 1'b1;
        pr = 1'b1;
        {e_wack, e_rack, e_werr, e_rerr} = 4'b0;
        e_rdata = 32'b0;
    endfunction

    // One clock: apply the register rules to the model, advance, then compare every output.
    task automatic cycle();
        logic [11:0] wa, ra;
        logic [31:0] wd;
        bit wacc, racc, set_ovf, set_ovr, clr_ovf, clr_ovr;
        wa = bus.waddr;
        ra = bus.raddr;
        wd = bus.wdata;
        wacc = bus.wr_en && !pw;
        racc = bus.rd_en && !pr;
        pw = bus.wr_en;
        pr = bus.rd_en;
        {set_ovf, set_ovr, clr_ovf, clr_ovr} = 4'b0;
        e_wack = wacc;
        e_rack = racc;
        e_werr = wacc && !(wa inside {12'h000, 12'h008, 12'h00C, 12'h010});
        e_rerr = racc && !(ra inside {12'h004, 12'h008, 12'h00C, 12'h010});
        e_rdata = 32'b0;
        if (racc) begin
            if (ra == 12'h004 && rx_q.size() > 0) e_rdata = {24'b0, rx_q[0]};
            if (ra == 12'h008) e_rdata = {30'b0, m_rxen, m_txen};
            if (ra == 12'h00C) e_rdata = {16'b0, m_baud};
            if (ra == 12'h010) e_rdata = m_status();
        end
        if (m_txen && tx_q.size() > 0 && tx_ready) void'(tx_q.pop_front());
        if (racc && ra == 12'h004 && rx_q.size() > 0) void'(rx_q.pop_front());
        if (wacc && wa == 12'h000) begin
            if (tx_q.size() < 8) tx_q.push_back(wd[7:0]);
            else set_ovf = 1'b1;
        end
        if (rx_valid && m_rxen) begin
            if (rx_q.size() < 8) rx_q.push_back(rx_data);
            else set_ovr = 1'b1;
        end
        if (wacc && wa == 12'h008) begin
            m_txen = wd[0];
            m_rxen = wd[1];
            if (wd[2]) tx_q.delete();
            if (wd[3]) rx_q.delete();
        end
        if (wacc && wa == 12'h00C) m_baud = wd[15:0];
        if (wacc && wa == 12'h010) begin
            clr_ovf = wd[13];
            clr_ovr = wd[12];
        end
        m_ovf = set_ovf || (m_ovf && !clr_ovf);
        m_ovr = set_ovr || (m_ovr && !clr_ovr);
        @(posedge pclk);
        @(negedge pclk);
        chk("wack", 32'(bus.wack), 32'(e_wack));
        chk("rack", 32'(bus.rack), 32'(e_rack));
        chk("waddrerr", 32'(bus.waddrerr & bus.wack), 32'(e_werr));
        chk("raddrerr", 32'(bus.raddrerr & bus.rack), 32'(e_rerr));
        chk("rdata", bus.rdata, e_rdata);
        chk("tx_en", 32'(tx_en), 32'(m_txen));
        chk("rx_en", 32'(rx_en), 32'(m_rxen));
        chk("baud_div", 32'(baud_div), 32'(m_baud));
        chk("tx_valid", 32'(tx_valid), 32'(m_txen && tx_q.size() > 0));
        if (m_txen && tx_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(tx_q[0]));
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, output logic ack, output logic err);
        bus.waddr = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        cycle();
        ack = bus.wack;
        err = bus.waddrerr;
        bus.wr_en = 1'b0;
        cycle();
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic ack, output logic err);
        bus.raddr = a;
        bus.rd_en = 1'b1;
        cycle();
        d = bus.rdata;
        ack = bus.rack;
        err = bus.raddrerr;
        bus.rd_en = 1'b0;
        cycle();
    endtask

    task automatic check_reset_values();
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_acks", {30'b0, bus.wack, bus.rack}, 32'h0);
        chk("rst_errs", {30'b0, bus.waddrerr, bus.raddrerr}, 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_en", {30'b0, tx_en, rx_en}, 32'h0);
        chk("rst_baud", 32'(baud_div), 32'd27);
    endtask

    logic [31:0] d;
    logic        a, e;
    logic [11:0] addrs[8] = '{12'h000, 12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h020, 12'hFFC};

    initial begin
        bus.waddr = '0; bus.wdata = '0; bus.wr_en = 1'b0;
        bus.raddr = '0; bus.rd_en = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        #2 prst_n = 1'b0;
        #1 check_reset_values();
        m_reset();
        @(negedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;
        cycle();

        // control write then read back
        wr(12'h008, 32'h3, a, e);
        rd(12'h008, d, a, e);
        chk("ctrl_rack", 32'(a), 32'h1);
        chk("ctrl_rdata", d, 32'h3);
        chk("ctrl_en", {30'b0, tx_en, rx_en}, 32'h3);
        wr(12'h008, 32'hC, a, e);

        // overfill TX with transmitter disabled
        for (int i = 0; i < 9; i++) wr(12'h000, 32'h41 + i, a, e);
        chk("ovf_wack", {30'b0, a, e}, 32'h2);
        rd(12'h010, d, a, e);
        chk("tx_cnt", (d >> 4) & 32'hF, 32'd8);
        chk("tx_full", d & 32'h1, 32'h1);
        chk("tx_overflow", (d >> 13) & 32'h1, 32'h1);

        // drain in order
        wr(12'h008, 32'h1, a, e);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 32'(tx_valid), 32'h1);
            chk("drain_data", 32'(tx_data), 32'h41 + i);
            cycle();
        end
        chk("drain_done", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // RX overrun
        wr(12'h008, 32'h3, a, e);
        rx_valid = 1'b1;
        rx_data = 8'h55;
        repeat (9) cycle();
        rx_valid = 1'b0;
        rd(12'h010, d, a, e);
        chk("rx_cnt8", (d >> 8) & 32'hF, 32'd8);
        chk("rx_overrun", (d >> 12) & 32'h1, 32'h1);
        rd(12'h004, d, a, e);
        chk("rx_pop", d, 32'h55);
        rd(12'h010, d, a, e);
        chk("rx_cnt7", (d >> 8) & 32'hF, 32'd7);

        // address errors
        rd(12'h020, d, a, e);
        chk("rerr", {d[29:0], a, e}, 32'h3);
        wr(12'h004, 32'hAA, a, e);
        chk("werr", {30'b0, a, e}, 32'h3);

        // held read pops once
        bus.raddr = 12'h004;
        bus.rd_en = 1'b1;
        cycle();
        chk("held_rack", 32'(bus.rack), 32'h1);
        cycle();
        cycle();
        bus.rd_en = 1'b0;
        cycle();
        rd(12'h010, d, a, e);
        chk("held_rx_cnt", (d >> 8) & 32'hF, 32'd6);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bus.wr_en = 1'($urandom_range(0, 1));
            bus.rd_en = 1'($urandom_range(0, 1));
            bus.waddr = addrs[$urandom_range(0, 7)];
            bus.raddr = addrs[$urandom_range(0, 7)];
            bus.wdata = $urandom;
            tx_ready = ($urandom_range(0, 3) == 0);
            rx_valid = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
            cycle();
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        cycle();

        // reset during a pending write, level still high at release
        wr(12'h00C, 32'h1234, a, e);
        wr(12'h008, 32'h3, a, e);
        bus.waddr = 12'h008;
        bus.wdata = 32'h3;
        bus.wr_en = 1'b1;
        #2 prst_n = 1'b0;
        #1 check_reset_values();
        m_reset();
        @(negedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;
        cycle();
        chk("no_ack_after_rst", 32'(bus.wack), 32'h0);
        cycle();
        bus.wr_en = 1'b0;
        cycle();
        rd(12'h008, d, a, e);
        chk("ctrl_after_rst", d, 32'h0);
        wr(12'h000, 32'h99, a, e);
        rd(12'h010, d, a, e);
        chk("status_after_rst", d, 32'h0000_0018);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
